// File: rtl/trace_pkg.sv
// Shared definitions for the commit-trace recorder: record kinds and packed record width.
// Pure declarations; no timing or flow control.
package trace_pkg;

   typedef enum logic [1:0] {
      TR_NOP   = 2'd0,
      TR_REG   = 2'd1,
      TR_STORE = 2'd2,
      TR_HALT  = 2'd3
   } trKind_e;

   // Packed layout: kind, ld, reg, pc, addr, value, inum (MSB to LSB).
   function automatic int recWidth(input int dataW, input int regAw, input int cntW);
      return 2 + 1 + regAw + 3 * dataW + cntW;
   endfunction

endpackage

// File: rtl/trace_ring.sv
// Show-ahead ring of DEPTH records; read data is combinational from the head, zero when empty.
// One push and one pop per cycle; when full a push overwrites the oldest (WRAP_MODE=1) or is dropped.
module trace_ring #(
   parameter int W         = 8,
   parameter int DEPTH     = 16,
   parameter int WRAP_MODE = 1
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     clear,
   input  logic                     push,
   input  logic [W-1:0]             pushData,
   input  logic                     popReady,
   output logic                     popValid,
   output logic [W-1:0]             popData,
   output logic [$clog2(DEPTH):0]   occupancy,
   output logic                     overflow
);

   localparam int PW = $clog2(DEPTH);
   localparam logic [PW:0] FULL_CNT = (PW + 1)'(DEPTH);
   localparam bit WRAP = (WRAP_MODE != 0);

   logic [W-1:0]  mem [DEPTH];
   logic [PW-1:0] head;
   logic [PW-1:0] tail;
   logic [PW:0]   count;
   logic          full;
   logic          pop;
   logic          wrEn;
   logic          overwrite;

   assign full      = (count == FULL_CNT);
   assign popValid  = (count != '0);
   assign pop       = popValid & popReady;
   // A pop in the same cycle frees a slot, so full+push+pop never counts as overflow.
   assign wrEn      = push & (!full | pop | WRAP);
   assign overwrite = push & full & !pop & WRAP;
   assign popData   = popValid ? mem[head] : '0;
   assign occupancy = count;

   always_ff @(posedge clk) begin
      if (!rst_n || clear) begin
         head     <= '0;
         tail     <= '0;
         count    <= '0;
         overflow <= 1'b0;
      end else begin
         if (wrEn)
            tail <= tail + 1'b1;
         if (pop || overwrite)
            head <= head + 1'b1;
         if (push && full && !pop)
            overflow <= 1'b1;
         if (wrEn && !pop && !full)
            count <= count + 1'b1;
         else if (pop && !wrEn)
            count <= count - 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (wrEn)
         mem[tail] <= pushData;
   end

endmodule

// File: rtl/commit_trace_buffer.sv
// Records one trace entry per retired instruction, with instruction/cycle counters, watchdog and sticky flags.
// Capture at edge N is readable from cycle N+1; drain via rd_valid/rd_ready, capture never stalls the CPU.
module commit_trace_buffer
   import trace_pkg::*;
#(
   parameter int DATA_W      = 16,
   parameter int REG_AW      = 4,
   parameter int DEPTH       = 16,
   parameter int CNT_W       = 32,
   parameter int CYCLE_LIMIT = 100000,
   parameter int WRAP_MODE   = 1
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   clear,
   input  logic                   cap_en,
   input  logic [DATA_W-1:0]      pc,
   input  logic [DATA_W-1:0]      mem_addr,
   input  logic [DATA_W-1:0]      wr_data,
   input  logic [DATA_W-1:0]      mem_data,
   input  logic                   reg_we,
   input  logic                   mem_re,
   input  logic                   mem_we,
   input  logic                   halt,
   input  logic [REG_AW-1:0]      wr_reg,
   output logic                   rd_valid,
   input  logic                   rd_ready,
   output logic [1:0]             rd_kind,
   output logic                   rd_ld,
   output logic [REG_AW-1:0]      rd_reg,
   output logic [DATA_W-1:0]      rd_pc,
   output logic [DATA_W-1:0]      rd_addr,
   output logic [DATA_W-1:0]      rd_value,
   output logic [CNT_W-1:0]       rd_inum,
   output logic [$clog2(DEPTH):0] occupancy,
   output logic [CNT_W-1:0]       inst_count,
   output logic [CNT_W-1:0]       cycle_count,
   output logic                   overflow,
   output logic                   halted,
   output logic                   timeout
);

   typedef struct packed {
      logic [1:0]        kind;
      logic              ld;
      logic [REG_AW-1:0] regIdx;
      logic [DATA_W-1:0] pc;
      logic [DATA_W-1:0] addr;
      logic [DATA_W-1:0] value;
      logic [CNT_W-1:0]  inum;
   } rec_t;

   localparam int REC_W = recWidth(DATA_W, REG_AW, CNT_W);
   localparam logic [CNT_W-1:0] LIMIT = CNT_W'(CYCLE_LIMIT);

   rec_t             capRec;
   rec_t             headRec;
   logic [REC_W-1:0] headBits;
   logic             frozen;
   logic             capture;
   logic [CNT_W-1:0] cycNext;

   assign frozen  = halted | timeout;
   assign capture = cap_en & !frozen;
   assign cycNext = cycle_count + 1'b1;

   // Kind priority halt > store > reg write > nop; fields the kind does not use stay zero.
   always_comb begin
      capRec      = '0;
      capRec.pc   = pc;
      capRec.inum = inst_count;
      if (halt) begin
         capRec.kind = TR_HALT;
      end else if (mem_we) begin
         capRec.kind  = TR_STORE;
         capRec.addr  = mem_addr;
         capRec.value = mem_data;
      end else if (reg_we) begin
         capRec.kind   = TR_REG;
         capRec.regIdx = wr_reg;
         capRec.value  = wr_data;
         capRec.ld     = mem_re;
         capRec.addr   = mem_re ? mem_addr : '0;
      end else begin
         capRec.kind = TR_NOP;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n || clear) begin
         inst_count  <= '0;
         cycle_count <= '0;
         halted      <= 1'b0;
         timeout     <= 1'b0;
      end else begin
         if (!frozen) begin
            cycle_count <= cycNext;
            if (cycNext == LIMIT)
               timeout <= 1'b1;
         end
         if (capture) begin
            inst_count <= inst_count + 1'b1;
            if (halt)
               halted <= 1'b1;
         end
      end
   end

   trace_ring #(
      .W         (REC_W),
      .DEPTH     (DEPTH),
      .WRAP_MODE (WRAP_MODE)
   ) uRing (
      .clk       (clk),
      .rst_n     (rst_n),
      .clear     (clear),
      .push      (capture),
      .pushData  (capRec),
      .popReady  (rd_ready),
      .popValid  (rd_valid),
      .popData   (headBits),
      .occupancy (occupancy),
      .overflow  (overflow)
   );

   assign headRec  = headBits;
   assign rd_kind  = headRec.kind;
   assign rd_ld    = headRec.ld;
   assign rd_reg   = headRec.regIdx;
   assign rd_pc    = headRec.pc;
   assign rd_addr  = headRec.addr;
   assign rd_value = headRec.value;
   assign rd_inum  = headRec.inum;

endmodule

// File: tb/tb_commit_trace_buffer.sv
// Scoreboard bench: three DEPTH=4 instances (wrap, drop, CYCLE_LIMIT=10) checked against a queue model every cycle.
module tb_commit_trace_buffer;

   typedef struct packed {
      logic [1:0]  kind;
      logic        ld;
      logic [3:0]  regIdx;
      logic [15:0] pc;
      logic [15:0] addr;
      logic [15:0] value;
      logic [31:0] inum;
   } rec_t;

   logic        clk = 1'b0;
   logic        rstN, clear, clearT, capEn, rdReady;
   logic        regWe, memRe, memWe, halt;
   logic [15:0] pc, memAddr, wrData, memData;
   logic [3:0]  wrReg;

   logic        rdValid [3];
   logic        rdLd [3];
   logic        overflow [3];
   logic        halted [3];
   logic        timeout [3];
   logic [1:0]  rdKind [3];
   logic [3:0]  rdReg [3];
   logic [15:0] rdPc [3];
   logic [15:0] rdAddr [3];
   logic [15:0] rdValue [3];
   logic [31:0] rdInum [3];
   logic [31:0] instCount [3];
   logic [31:0] cycleCount [3];
   logic [2:0]  occ [3];

   always #5 clk = ~clk;

   // Instance 0: overwrite when full, 1: drop when full, 2: watchdog at 10 cycles, never captures.
   for (genvar g = 0; g < 3; g++) begin : gDut
      commit_trace_buffer #(
         .DATA_W      (16),
         .REG_AW      (4),
         .DEPTH       (4),
         .CNT_W       (32),
         .CYCLE_LIMIT ((g == 2) ? 10 : 100000),
         .WRAP_MODE   ((g == 1) ? 0 : 1)
      ) dut (
         .clk         (clk),
         .rst_n       (rstN),
         .clear       ((g == 2) ? clearT : clear),
         .cap_en      ((g == 2) ? 1'b0 : capEn),
         .pc          (pc),
         .mem_addr    (memAddr),
         .wr_data     (wrData),
         .mem_data    (memData),
         .reg_we      (regWe),
         .mem_re      (memRe),
         .mem_we      (memWe),
         .halt        (halt),
         .wr_reg      (wrReg),
         .rd_valid    (rdValid[g]),
         .rd_ready    ((g == 2) ? 1'b0 : rdReady),
         .rd_kind     (rdKind[g]),
         .rd_ld       (rdLd[g]),
         .rd_reg      (rdReg[g]),
         .rd_pc       (rdPc[g]),
         .rd_addr     (rdAddr[g]),
         .rd_value    (rdValue[g]),
         .rd_inum     (rdInum[g]),
         .occupancy   (occ[g]),
         .inst_count  (instCount[g]),
         .cycle_count (cycleCount[g]),
         .overflow    (overflow[g]),
         .halted      (halted[g]),
         .timeout     (timeout[g])
      );
   end

   rec_t headW, headD;
   assign headW = {rdKind[0], rdLd[0], rdReg[0], rdPc[0], rdAddr[0], rdValue[0], rdInum[0]};
   assign headD = {rdKind[1], rdLd[1], rdReg[1], rdPc[1], rdAddr[1], rdValue[1], rdInum[1]};

   rec_t        sbW[$];
   rec_t        sbD[$];
   logic [31:0] expInst, expCyc, cycT;
   logic        expOvW, expOvD, expHalted, toT;
   int          checks = 0;
   int          passes = 0;

   task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
      checks++;
      if (got === exp)
         passes++;
      else
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   function automatic rec_t mkRec(input logic [31:0] inum);
      rec_t r;
      r      = '0;
      r.pc   = pc;
      r.inum = inum;
      if (halt) begin
         r.kind = 2'd3;
      end else if (memWe) begin
         r.kind  = 2'd2;
         r.addr  = memAddr;
         r.value = memData;
      end else if (regWe) begin
         r.kind   = 2'd1;
         r.regIdx = wrReg;
         r.value  = wrData;
         r.ld     = memRe;
         if (memRe)
            r.addr = memAddr;
      end
      return r;
   endfunction

   task automatic setCap(input logic en, input logic h, input logic st, input logic rw, input logic ld,
                         input logic [15:0] p, input logic [15:0] a, input logic [15:0] wd,
                         input logic [15:0] md, input logic [3:0] rg);
      capEn = en; halt = h; memWe = st; regWe = rw; memRe = ld;
      pc = p; memAddr = a; wrData = wd; memData = md; wrReg = rg;
   endtask

   // Check all outputs against the model at the falling edge, then advance the model across the next rising edge.
   task automatic tick();
      rec_t r, dump;
      bit   popW, popD, nextHalt;
      @(negedge clk);
      chk("occW", 128'(occ[0]), 128'(sbW.size()));
      chk("occD", 128'(occ[1]), 128'(sbD.size()));
      chk("validW", 128'(rdValid[0]), 128'(sbW.size() != 0));
      chk("validD", 128'(rdValid[1]), 128'(sbD.size() != 0));
      if (sbW.size() != 0) chk("headW", 128'(headW), 128'(sbW[0]));
      else                 chk("headW0", 128'(headW), 128'(0));
      if (sbD.size() != 0) chk("headD", 128'(headD), 128'(sbD[0]));
      else                 chk("headD0", 128'(headD), 128'(0));
      chk("ovW", 128'(overflow[0]), 128'(expOvW));
      chk("ovD", 128'(overflow[1]), 128'(expOvD));
      chk("instW", 128'(instCount[0]), 128'(expInst));
      chk("instD", 128'(instCount[1]), 128'(expInst));
      chk("cycW", 128'(cycleCount[0]), 128'(expCyc));
      chk("cycD", 128'(cycleCount[1]), 128'(expCyc));
      chk("haltW", 128'(halted[0]), 128'(expHalted));
      chk("haltD", 128'(halted[1]), 128'(expHalted));
      chk("toWD", 128'({timeout[0], timeout[1]}), 128'(0));
      chk("cycT", 128'(cycleCount[2]), 128'(cycT));
      chk("toT", 128'(timeout[2]), 128'(toT));
      chk("occT", 128'({rdValid[2], occ[2]}), 128'(0));

      popW = rdReady && (sbW.size() != 0);
      popD = rdReady && (sbD.size() != 0);
      nextHalt = 1'b0;
      if (!rstN || clear) begin
         sbW.delete(); sbD.delete();
         expInst = 0; expCyc = 0; expOvW = 0; expOvD = 0; expHalted = 0;
      end else begin
         if (popW) dump = sbW.pop_front();
         if (popD) dump = sbD.pop_front();
         if (capEn && !expHalted) begin
            r = mkRec(expInst);
            expInst++;
            if (sbW.size() == 4) begin
               dump   = sbW.pop_front();
               expOvW = 1'b1;
            end
            sbW.push_back(r);
            if (sbD.size() == 4) expOvD = 1'b1;
            else                 sbD.push_back(r);
            nextHalt = (r.kind == 2'd3);
         end
         if (!expHalted) expCyc++;
         if (nextHalt) expHalted = 1'b1;
      end
      if (!rstN || clearT) begin
         cycT = 0; toT = 0;
      end else if (!toT) begin
         cycT++;
         if (cycT == 10) toT = 1'b1;
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      rstN = 0; clear = 0; clearT = 0; rdReady = 0;
      setCap(0, 0, 0, 0, 0, 16'h0, 16'h0, 16'h0, 16'h0, 4'h0);
      sbW.delete(); sbD.delete();
      expInst = 0; expCyc = 0; cycT = 0;
      expOvW = 0; expOvD = 0; expHalted = 0; toT = 0;
      @(posedge clk);
      #1;
      tick();
      rstN = 1;

      // Basic order: REG, STORE, NOP held, then drained.
      setCap(1, 0, 0, 1, 0, 16'h0002, 16'h0055, 16'h00AA, 16'h7777, 4'd3); tick();
      setCap(1, 0, 1, 0, 0, 16'h0004, 16'h0040, 16'hBEEF, 16'h1234, 4'd5); tick();
      setCap(1, 0, 0, 0, 0, 16'h0006, 16'h0099, 16'h1111, 16'h2222, 4'd7); tick();
      capEn = 0; tick();
      rdReady = 1; repeat (4) tick();

      // Six captures with no pops: wrap keeps 2..5, drop keeps 0..3.
      rdReady = 0; clear = 1; tick(); clear = 0;
      for (int i = 0; i < 6; i++) begin
         setCap(1, 0, 0, 1, 0, 16'(i * 2), 16'h0300, 16'(16'h0100 + i), 16'h0, 4'(i));
         tick();
      end
      capEn = 0; tick();
      rdReady = 1; repeat (5) tick();

      // Full buffer with simultaneous push and pop.
      rdReady = 0; clear = 1; tick(); clear = 0;
      for (int i = 0; i < 4; i++) begin
         setCap(1, 0, 1, 0, 0, 16'(16'h0020 + i), 16'(16'h0400 + i), 16'h0, 16'(16'h0500 + i), 4'd0);
         tick();
      end
      setCap(1, 0, 0, 1, 1, 16'h0030, 16'h0600, 16'h0700, 16'h0, 4'd9);
      rdReady = 1; tick();
      capEn = 0; rdReady = 0; tick();
      rdReady = 1; repeat (5) tick();

      // Load, then halt (with reg_we also set), then captures that must be ignored.
      rdReady = 0; clear = 1; tick(); clear = 0;
      setCap(1, 0, 0, 1, 1, 16'h0040, 16'h0080, 16'h003C, 16'h0, 4'd2); tick();
      setCap(1, 1, 0, 1, 0, 16'h0042, 16'h0081, 16'h0044, 16'h0055, 4'd4); tick();
      setCap(1, 0, 1, 0, 0, 16'h0044, 16'h0082, 16'h0, 16'h0066, 4'd0); tick();
      tick();
      capEn = 0; tick();
      rdReady = 1; repeat (3) tick();

      // Reset while draining three entries.
      rdReady = 0; clear = 1; tick(); clear = 0;
      for (int i = 0; i < 3; i++) begin
         setCap(1, 0, 0, 0, 0, 16'(16'h0050 + i), 16'h0, 16'h0, 16'h0, 4'd0);
         tick();
      end
      capEn = 0; rdReady = 1; rstN = 0; tick();
      rstN = 1; tick();
      rdReady = 0;
      setCap(1, 0, 0, 1, 0, 16'h0060, 16'h0, 16'h00F0, 16'h0, 4'd1); tick();
      capEn = 0; tick();
      rdReady = 1; repeat (2) tick();

      // Watchdog instance restarted and run past its limit.
      rdReady = 0; clearT = 1; tick(); clearT = 0;
      repeat (14) tick();

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule

// File: doc/commit_trace_buffer.md
# commit_trace_buffer

Synthesizable commit-trace recorder that sits beside the single-cycle `cpu` and captures one record per retired instruction (register write, load, store, branch/NOP, halt) into a parametrised ring buffer. Records are drained through a valid/ready read port. The block also maintains instruction and cycle counters, a cycle-limit watchdog and sticky status flags, so trace capture works on silicon/FPGA without a simulation-only bench.

## Interface
- `DATA_W`, 16, width of PC, address and data fields
- `REG_AW`, 4, register-index width
- `DEPTH`, 16, ring entries; power of two, ≥2
- `CNT_W`, 32, width of instruction and cycle counters
- `CYCLE_LIMIT`, 100000, watchdog limit in cycles; must be < 2^CNT_W
- `WRAP_MODE`, 1, 1 = overwrite oldest entry when full; 0 = drop new entry when full

Ports:
- `clk` in 1: sole clock, rising edge
- `rst_n` in 1: reset, synchronous, active-low
- `clear` in 1: synchronous soft clear, same effect as reset
- `cap_en` in 1: capture enable; the CPU is retiring an instruction this cycle
- `pc`, `mem_addr`, `wr_data`, `mem_data` in DATA_W: retire-cycle observables
- `reg_we`, `mem_re`, `mem_we`, `halt` in 1: retire-cycle controls
- `wr_reg` in REG_AW: destination register
- `rd_valid` out 1: head record available
- `rd_ready` in 1: consumer accepts the head record
- `rd_kind` out 2: record kind, 0 NOP/branch, 1 REG, 2 STORE, 3 HALT
- `rd_ld` out 1: REG record originated from a load
- `rd_reg` out REG_AW; `rd_pc`, `rd_addr`, `rd_value` out DATA_W; `rd_inum` out CNT_W
- `occupancy` out clog2(DEPTH)+1
- `inst_count`, `cycle_count` out CNT_W
- `overflow`, `halted`, `timeout` out 1: sticky flags

## Operation
- **Frozen state.** `frozen = halted | timeout`. While frozen, no capture takes place and `cycle_count` holds. Draining continues while frozen.
- **Cycle counter.** `cycle_count` increments every non-frozen cycle. When the incremented value equals CYCLE_LIMIT, `timeout` is set on that same edge.
- **Capture.** A capture occurs on a cycle with `cap_en & !frozen`. Each capture forms one record, with kind chosen by priority:
  - `halt` → HALT
  - `mem_we` → STORE: addr = `mem_addr`, value = `mem_data`
  - `reg_we` → REG: reg = `wr_reg`, value = `wr_data`, ld = `mem_re`, addr = `mem_addr` if ld else 0
  - otherwise → NOP/branch
  - Fields unused by the chosen kind are stored as 0.
  - `inum` = `inst_count` before the capture; `inst_count` increments on every capture, including dropped ones.
- **HALT capture.** Sets `halted` on the same edge; capture stops from the next cycle.
- **Pop.** A pop occurs when `rd_valid & rd_ready`; the head advances.
- **Full, push without pop:**
  - WRAP_MODE=1: overwrite the oldest entry, advance the head, set `overflow`.
  - WRAP_MODE=0: discard the new record and set `overflow`.
- **Full, push with simultaneous pop.** Both succeed, occupancy stays DEPTH, `overflow` is unchanged. This holds in both modes.
- **Empty, simultaneous push.** The pop cannot occur because `rd_valid` = 0; the record is written and occupancy becomes 1.
- **Pointers.** Pointers are clog2(DEPTH) bits and wrap modulo DEPTH. Occupancy is tracked as a separate counter.
- **Reset/clear.** `rst_n`=0 or `clear`=1 empties the buffer, zeroes both counters and clears all flags. Reset takes priority over any simultaneous push or pop, including a reset mid-drain.
- **Output forcing.** All `rd_*` data outputs are forced to 0 while `rd_valid` = 0.

## Timing
- **Reset values.** Every output is 0 after reset.
- **Capture latency.** A record captured at edge N is visible on `rd_*` (with `rd_valid`=1) after edge N; the consumer sees it in cycle N+1.
- **Read path.** The `rd_*` outputs are a combinational read of the head entry (show-ahead FIFO).
- **Handshake.** `rd_valid` stays high until the pop and does not depend on `rd_ready`. Head data is stable while `rd_valid & !rd_ready`.
- **Status outputs.** `occupancy`, the counters and the flags are registered and reflect the state after the most recent edge.
- **Throughput.** One capture and one pop per cycle.

## Structure
- **Package `trace_pkg`:**
  - kind constants `TR_NOP`, `TR_REG`, `TR_STORE`, `TR_HALT`
  - record struct/width function of DATA_W, REG_AW, CNT_W
- **Sub-module `trace_ring`:** parametrised storage array with head/tail pointers, occupancy, overwrite/drop logic and the read port.
- **Top level `commit_trace_buffer`:** record formation, counters, watchdog and flags.

## Test plan
- **Basic order.** DEPTH=4; capture REG r3=0x00AA at pc 0x0002, STORE 0x1234→0x0040, NOP at 0x0006, with `rd_ready`=0 → occupancy 3. Draining returns kinds 1, 2, 0 with inum 0, 1, 2 and correct fields.
- **Wrap overflow.** WRAP_MODE=1, DEPTH=4; 6 captures, no pops → occupancy 4, `overflow`=1, drained inums 2..5.
- **Drop overflow.** WRAP_MODE=0, DEPTH=4; 6 captures, no pops → drained inums 0..3, `overflow`=1, `inst_count`=6.
- **Full push+pop.** DEPTH=4 full; push with `rd_ready`=1 → occupancy stays 4, `overflow` stays 0, new head is inum+1.
- **Halt and watchdog.** Capture a load REG then `halt` → HALT record, `halted`=1; further `cap_en` is ignored and `cycle_count` freezes. Separately, with CYCLE_LIMIT=10 and no halt → `timeout`=1 and `cycle_count`=10, both held.
- **Reset mid-drain.** Assert `rst_n`=0 for 1 cycle with occupancy 3 and `rd_ready`=1 → all outputs 0 on the next cycle, and the next capture gets inum 0.
